// File: rtl/psum_drain_pkg.sv
// Shared types for the psum drain block: FSM state encoding
// and the channel-index width helper.
package psum_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a channel index for n elements (n >= 2).
    function automatic int ch_idx_bw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/psum_clamp.sv
// Combinational unsigned min(i_val, MAX) at W bits.
// Ports: i_val (element in), o_val (clamped element out).
module psum_clamp #(
    parameter int W   = 16,
    parameter int MAX = 255
) (
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    localparam logic [W-1:0] LIM = W'(MAX);

    assign o_val = (i_val > LIM) ? LIM : i_val;

endmodule

// File: rtl/psum_drain.sv
// Parallel-to-serial drain: captures one frame of input_ch psums
// in one cycle and streams them ch0..chN-1 over valid/ready with
// output SRAM addresses (frame_base + ch, modulo 2^addr_bw).
// Ports: clk, reset (async active-low), load/psums_in/load_ready
// (frame capture), out_valid/out_ready/out_data/out_ch/out_addr
// (beat stream), done (1-cycle pulse after the last beat).
// Define PSUM_DRAIN_CLAMP_EN to clamp out_data to clamp_max.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int psum_bw   = 16,
    parameter int input_ch  = 16,
    parameter int addr_bw   = 8,
    parameter int clamp_max = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic [psum_bw*input_ch-1:0]  psums_in,
    output logic                         load_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [psum_bw-1:0]           out_data,
    output logic [ch_idx_bw(input_ch)-1:0] out_ch,
    output logic [addr_bw-1:0]           out_addr,
    output logic                         done
);

    localparam int CH_IDX_BW = ch_idx_bw(input_ch);
    localparam logic [CH_IDX_BW-1:0] LAST_CH =
        CH_IDX_BW'(input_ch - 1);
    localparam logic [addr_bw-1:0] FRAME_INC =
        addr_bw'(input_ch);

    state_t                        r_state;
    logic [psum_bw*input_ch-1:0]   r_shadow;
    logic [CH_IDX_BW-1:0]          r_ch;
    logic [addr_bw-1:0]            r_base;
    logic                          r_valid;
    logic                          r_done;
    logic                          r_load_ready;

    logic [psum_bw-1:0]            w_elem;
    logic [psum_bw-1:0]            w_data;

    assign w_elem = r_shadow[psum_bw*int'(r_ch) +: psum_bw];

`ifdef PSUM_DRAIN_CLAMP_EN
    psum_clamp #(
        .W   (psum_bw),
        .MAX (clamp_max)
    ) u_clamp (
        .i_val (w_elem),
        .o_val (w_data)
    );
`else
    assign w_data = w_elem;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_shadow     <= '0;
            r_ch         <= '0;
            r_base       <= '0;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shadow     <= psums_in;
                        r_ch         <= '0;
                        r_valid      <= 1'b1;
                        r_load_ready <= 1'b0;
                        r_state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        // ch parks on the last index so it never
                        // leaves the element range.
                        if (r_ch == LAST_CH) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_base  <= r_base + FRAME_INC;
                            r_state <= DONE;
                        end else begin
                            r_ch <= r_ch + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_done       <= 1'b0;
                    r_load_ready <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_valid      <= 1'b0;
                    r_done       <= 1'b0;
                    r_load_ready <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign load_ready = r_load_ready;
    assign out_valid  = r_valid;
    assign out_data   = w_data;
    assign out_ch     = r_ch;
    assign out_addr   = r_base + addr_bw'(r_ch);
    assign done       = r_done;

endmodule
